avalon_pio_irq: RTL
===================

// Module: avalon_pio_irq
// PURPOSE
// - Parametrised Avalon-MM slave PIO: DATA_WIDTH-bit output register plus synchronised input port.
// - Adds atomic set/clear of output bits, per-bit edge capture on inputs, maskable level IRQ.
// - Sits on the Nios system interconnect next to existing output-only PIOs; drives LEDs/strobes, samples keys/switches.
// PARAMETERS
// DATA_WIDTH   4   width of out_port, in_port and all data registers (1..32)
// RESET_VALUE  0   out_port value at reset (DATA_WIDTH bits)
// SYNC_STAGES  2   flip-flops in in_port synchroniser (>=2)
// EDGE_TYPE    0   0 = rising, 1 = falling, 2 = any edge captured
// PORTS
// clk        in   1           system clock
// reset_n    in   1           asynchronous active-low reset
// address    in   3           word address (register map below)
// chipselect in   1           slave select
// write_n    in   1           active-low write strobe; write when chipselect && !write_n
// writedata  in   32          write data; bits above DATA_WIDTH ignored
// readdata   out  32          read data, zero-extended; combinational from address/registers
// in_port    in   DATA_WIDTH  asynchronous external inputs
// out_port   out  DATA_WIDTH  output register
// irq        out  1           level interrupt, active high
// BEHAVIOUR
// - Reset: out_reg = RESET_VALUE; irq_mask = 0; edge_cap = 0; sync chain and prev = 0; arm counter = 0; irq = 0.
// - Register map (address): 0 OUT rw | 1 IN ro | 2 IRQ_MASK rw | 3 EDGE_CAP r, write-1-clear
//   | 4 OUTSET wo, out_reg |= wd | 5 OUTCLR wo, out_reg &= ~wd | 6,7 reserved.
// - Reads: 0 read latency; OUT/IN/IRQ_MASK/EDGE_CAP return register; 4..7 read 0; upper bits 0.
// - Writes take effect on the clk edge of the write cycle; writes to IN and 6/7 ignored.
// - out_port = out_reg directly; new value visible cycle after write.
// - IN = last synchroniser stage; in_port change visible at address 1 SYNC_STAGES cycles later.
// - Edge detect: compare sync output with prev (registered copy); per EDGE_TYPE set edge_cap bit.
// - Edge captured SYNC_STAGES+1 cycles after in_port change; bit stays set until cleared.
// - Simultaneous W1C clear and new edge on same bit: set wins (bit stays 1).
// - Arm counter: after reset, edge detection suppressed for SYNC_STAGES+1 cycles, then armed
//   permanently; prevents spurious edges from inputs already high at reset release.
// - irq = |(edge_cap & irq_mask), registered: asserts cycle after edge_cap/mask condition true,
//   deasserts cycle after last qualifying bit cleared or masked.
// - Mask does not gate capture: masked bits still record edges; unmasking later raises irq.
// - Reset mid-operation: all state returns to reset values asynchronously; arm sequence restarts.
// - Pulses shorter than one clk period not guaranteed captured.
// STRUCTURE
// - Package pio_pkg: register address constants (ADDR_OUT..ADDR_OUTCLR), EDGE_TYPE encodings.
// - Sub-module pio_sync_edge: synchroniser chain, prev register, arm counter, edge vector out
//   (params DATA_WIDTH, SYNC_STAGES, EDGE_TYPE). Top holds registers, read mux, irq.
// TESTING
// - Reset: DATA_WIDTH=4, RESET_VALUE=4'hA -> out_port=A, irq=0, read addr0=0000000A, addr3=0.
// - Set/clear: write 0=0x3, 4=0xC, 5=0x5 -> out_port 3, F, A on successive cycles; readback matches.
// - Sync latency: in_port 0->4'h6 -> addr1 reads 6 exactly SYNC_STAGES cycles later; EDGE_TYPE=0
//   -> edge_cap=6 one cycle after that.
// - IRQ: mask=0x2, rising edge bit1 -> irq=1 cycle after capture; W1C addr3=0x2 -> irq=0 next cycle;
//   edge bit0 with mask 0x2 -> edge_cap=1, irq stays 0; set mask=0x1 -> irq=1.
// - Collision: W1C bit1 in same cycle as new rising edge bit1 -> edge_cap bit1 remains 1.
// - Arm: in_port=4'hF held through reset release -> edge_cap stays 0; async reset mid-run clears all.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared register map and edge-type encodings for the IRQ-capable PIO.
package pio_pkg;

  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_IN       = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-value register and post-reset arm counter.
// Produces the synchronised input word and a one-cycle edge vector that is
// held at zero until the synchroniser has flushed its reset contents.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] sync_out,
  output logic [DATA_WIDTH-1:0] edge_vec
);

  // Arming waits for the chain plus the prev register to hold real samples.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_chain;
  logic [DATA_WIDTH-1:0]                  prev;
  logic [CNT_W-1:0]                       arm_cnt;
  logic                                   armed;
  logic [DATA_WIDTH-1:0]                  raw_edge;

  assign sync_out = sync_chain[SYNC_STAGES-1];
  assign armed    = (arm_cnt == ARM_LAST);

  // Metastability chain: stage 0 samples the pin, last stage feeds the logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_port};
    end
  end

  // Previous synchronised value for edge comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync_out;
    end
  end

  // Saturating arm counter; once full, edge detection stays enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // Edge selection by polarity, gated until armed.
  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: raw_edge = ~sync_out & prev;
      EDGE_ANY:     raw_edge = sync_out ^ prev;
      default:      raw_edge = sync_out & ~prev;
    endcase
    edge_vec = armed ? raw_edge : '0;
  end

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO slave: output register with atomic set/clear, synchronised
// input port, per-bit edge capture and a maskable registered level interrupt.
module avalon_pio_irq
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] edge_vec;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_wd_bits;

  assign wr_en          = chipselect & ~write_n;
  assign wd             = writedata[DATA_WIDTH-1:0];
  assign out_port       = out_reg;
  assign unused_wd_bits = ^writedata;

  pio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_out(in_sync),
    .edge_vec(edge_vec)
  );

  // Output register: plain write, atomic set and atomic clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_OUT:    out_reg <= wd;
        ADDR_OUTSET: out_reg <= out_reg | wd;
        ADDR_OUTCLR: out_reg <= out_reg & ~wd;
        default:     out_reg <= out_reg;
      endcase
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_IRQ_MASK) begin
      irq_mask <= wd;
    end
  end

  // Sticky edge capture; a new edge overrides a same-cycle write-1-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else if (wr_en && address == ADDR_EDGE_CAP) begin
      edge_cap <= (edge_cap & ~wd) | edge_vec;
    end else begin
      edge_cap <= edge_cap | edge_vec;
    end
  end

  // Registered level interrupt from captured and enabled bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_OUT:      rd_word = out_reg;
      ADDR_IN:       rd_word = in_sync;
      ADDR_IRQ_MASK: rd_word = irq_mask;
      ADDR_EDGE_CAP: rd_word = edge_cap;
      default:       rd_word = '0;
    endcase
    readdata                 = '0;
    readdata[DATA_WIDTH-1:0] = rd_word;
  end

endmodule
